// File: rtl/exp_align_if.sv
// Operand/result bundle for exp_align_pipe: input handshake with per-lane regime/exponent
// fields, output handshake with the aligned maximum scale and per-lane shifts.
interface exp_align_if #(
    parameter int unsigned n  = 16,
    parameter int unsigned es = 1,
    parameter int unsigned N  = 4
);
    localparam int unsigned LZC_WIDTH = $clog2(n - 1);
    localparam int unsigned EXP_WIDTH = LZC_WIDTH + 1 + es;
    localparam int unsigned SW        = EXP_WIDTH + 2;
    localparam int unsigned KW        = LZC_WIDTH + 1;
    localparam int unsigned EW        = es + 1;

    logic                   in_valid_i;
    logic                   in_ready_o;
    logic [N*KW-1:0]        k_sgn_a_i;
    logic [N*EW-1:0]        exp_a_i;
    logic [N*KW-1:0]        k_sgn_b_i;
    logic [N*EW-1:0]        exp_b_i;
    logic [N-1:0]           zero_i;
    logic                   out_valid_o;
    logic                   out_ready_i;
    logic [EXP_WIDTH:0]     max_exp_o;
    logic [N*SW-1:0]        shift_o;
    logic [N-1:0]           zero_o;
    logic                   all_zero_o;

    modport master (
        output in_valid_i, k_sgn_a_i, exp_a_i, k_sgn_b_i, exp_b_i, zero_i, out_ready_i,
        input  in_ready_o, out_valid_o, max_exp_o, shift_o, zero_o, all_zero_o
    );

    modport slave (
        input  in_valid_i, k_sgn_a_i, exp_a_i, k_sgn_b_i, exp_b_i, zero_i, out_ready_i,
        output in_ready_o, out_valid_o, max_exp_o, shift_o, zero_o, all_zero_o
    );
endinterface

// File: rtl/exp_align_pipe.sv
// Two-stage posit product exponent alignment: S1 forms per-lane product scales, S2 finds the
// maximum over non-zero lanes and the per-lane right-shift needed to align to it.
module exp_align_pipe #(
    parameter int unsigned n  = 16,
    parameter int unsigned es = 1,
    parameter int unsigned N  = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    exp_align_if.slave  bus
);
    localparam int unsigned LZC_WIDTH = $clog2(n - 1);
    localparam int unsigned EXP_WIDTH = LZC_WIDTH + 1 + es;
    localparam int unsigned SW        = EXP_WIDTH + 2;
    localparam int unsigned KW        = LZC_WIDTH + 1;
    localparam int unsigned KSW       = LZC_WIDTH + 2;
    localparam int unsigned EW        = es + 1;
    localparam int unsigned SCW       = EXP_WIDTH + 1;

    logic                   s1_load, s2_load;
    logic                   v1_d, v1_q, v2_d, v2_q;
    logic [N-1:0][EW-1:0]   raw;
    logic [N-1:0][KSW-1:0]  ks;
    logic [N-1:0][SCW-1:0]  lane_scale;
    logic [N-1:0][SCW-1:0]  scale_d, scale_q;
    logic [N-1:0]           zero1_d, zero1_q;
    logic signed [SCW-1:0]  mx;
    logic                   found;
    logic [SCW-1:0]         max_exp_d, max_exp_q;
    logic [N-1:0][SW-1:0]   shift_d, shift_q;
    logic [N-1:0]           zero2_d, zero2_q;
    logic                   all_zero_d, all_zero_q;

    // Regime sum carries the exponent overflow bit; sign-extend before adding.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            raw[i] = bus.exp_a_i[i*EW +: EW] + bus.exp_b_i[i*EW +: EW];
            ks[i]  = KSW'($signed(bus.k_sgn_a_i[i*KW +: KW]))
                   + KSW'($signed(bus.k_sgn_b_i[i*KW +: KW]))
                   + KSW'(raw[i][es]);
        end
    end

    if (es == 0) begin : g_es0
        always_comb begin
            for (int i = 0; i < N; i++) lane_scale[i] = ks[i];
        end
    end else begin : g_es
        always_comb begin
            for (int i = 0; i < N; i++) lane_scale[i] = {ks[i], raw[i][es-1:0]};
        end
    end

    always_comb begin
        s2_load = v1_q && (!v2_q || bus.out_ready_i);
        s1_load = !v1_q || s2_load;
        v1_d    = s1_load ? bus.in_valid_i : v1_q;
        v2_d    = s2_load ? 1'b1 : (v2_q && !bus.out_ready_i);

        scale_d = scale_q;
        zero1_d = zero1_q;
        if (s1_load && bus.in_valid_i) begin
            scale_d = lane_scale;
            zero1_d = bus.zero_i;
        end
    end

    // Zero lanes never win the max; with every lane zero the max stays 0.
    always_comb begin
        mx    = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!zero1_q[i] && (!found || $signed(scale_q[i]) > mx)) begin
                mx    = $signed(scale_q[i]);
                found = 1'b1;
            end
        end

        max_exp_d  = max_exp_q;
        shift_d    = shift_q;
        zero2_d    = zero2_q;
        all_zero_d = all_zero_q;
        if (s2_load) begin
            max_exp_d  = mx;
            zero2_d    = zero1_q;
            all_zero_d = &zero1_q;
            for (int i = 0; i < N; i++) begin
                // One extra bit of width keeps max - scale non-negative and unwrapped.
                shift_d[i] = zero1_q[i] ? '0
                           : SW'(SW'(mx) - SW'($signed(scale_q[i])));
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            v1_q       <= 1'b0;
            v2_q       <= 1'b0;
            scale_q    <= '0;
            zero1_q    <= '0;
            max_exp_q  <= '0;
            shift_q    <= '0;
            zero2_q    <= '0;
            all_zero_q <= 1'b0;
        end else begin
            v1_q       <= v1_d;
            v2_q       <= v2_d;
            scale_q    <= scale_d;
            zero1_q    <= zero1_d;
            max_exp_q  <= max_exp_d;
            shift_q    <= shift_d;
            zero2_q    <= zero2_d;
            all_zero_q <= all_zero_d;
        end
    end

    assign bus.in_ready_o  = s1_load;
    assign bus.out_valid_o = v2_q;
    assign bus.max_exp_o   = max_exp_q;
    assign bus.shift_o     = shift_q;
    assign bus.zero_o      = zero2_q;
    assign bus.all_zero_o  = all_zero_q;
endmodule
